uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_timeout_ctr.sv | 29 ++
 rtl/uart_cmd_parser.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command parser.
// Frame start byte, error-code encodings and the parser state enum.
package uart_pkg;

    localparam logic [7:0] SOF = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } parser_state_t;

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte idle counter for the UART command parser.
// expired fires on the enabled cycle whose tick brings the count to LIMIT.
module uart_timeout_ctr #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser: SOF 0xA5, LEN, LEN payload bytes streamed out, optional CHK byte.
// Define UART_PARSER_CSUM_EN to require and verify the trailing checksum byte.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_empty,
    input  logic [7:0] rdata,
    output logic       rduart,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frm_ok,
    output logic       frm_err,
    output logic [1:0] err_code
);

    parser_state_t state, state_n;
    logic       cap;
    logic       frm_ok_q, ok_now;
    logic [7:0] len, cnt, sum;
    logic [7:0] len_n, cnt_n, sum_n, m_data_n;
    logic       rd_n, m_valid_n, m_last_n, ok_n, err_n;
    logic [1:0] code_n;
    logic       accept, out_free, outstanding, payload_done, need_byte;
    logic       tmo_en, tmo_clr, tmo_expired;

    assign accept       = m_valid && m_ready;
    assign out_free     = !m_valid || m_ready;
    assign outstanding  = rduart || cap;
    assign payload_done = (state == PAYLOAD) && (cnt == len);
    assign need_byte    = (state != HUNT) && !payload_done;
    // A consumer stall is not an idle line, so the counter freezes while a byte is held.
    assign tmo_en       = need_byte && rx_empty && !outstanding && !(m_valid && !m_ready);
    assign tmo_clr      = cap || (state == HUNT);

`ifdef UART_PARSER_CSUM_EN
    assign ok_now = 1'b0;
`else
    assign ok_now = accept && m_last && (state == PAYLOAD);
`endif
    assign frm_ok = frm_ok_q | ok_now;

    uart_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HUNT;
            rduart   <= 1'b0;
            cap      <= 1'b0;
            m_data   <= 8'd0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            frm_ok_q <= 1'b0;
            frm_err  <= 1'b0;
            err_code <= ERR_NONE;
            len      <= 8'd0;
            cnt      <= 8'd0;
            sum      <= 8'd0;
        end else begin
            state    <= state_n;
            rduart   <= rd_n;
            cap      <= rduart;
            m_data   <= m_data_n;
            m_valid  <= m_valid_n;
            m_last   <= m_last_n;
            frm_ok_q <= ok_n;
            frm_err  <= err_n;
            err_code <= code_n;
            len      <= len_n;
            cnt      <= cnt_n;
            sum      <= sum_n;
        end
    end

    // Reads are decided two cycles ahead of the capture, so payload/check reads
    // wait until the output register is empty or draining this cycle.
    always_comb begin
        state_n   = state;
        m_data_n  = m_data;
        m_valid_n = accept ? 1'b0 : m_valid;
        m_last_n  = accept ? 1'b0 : m_last;
        ok_n      = 1'b0;
        err_n     = 1'b0;
        code_n    = err_code;
        len_n     = len;
        cnt_n     = cnt;
        sum_n     = sum;
        rd_n      = !rx_empty && !outstanding && !payload_done &&
                    (((state == PAYLOAD) || (state == CHECK)) ? out_free : 1'b1);

        case (state)
            HUNT: begin
                if (cap && (rdata == SOF)) state_n = LEN;
            end
            LEN: begin
                if (cap) begin
                    if ((rdata == 8'd0) || (rdata > 8'(MAX_LEN))) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LEN;
                        state_n = HUNT;
                    end else begin
                        len_n   = rdata;
                        cnt_n   = 8'd0;
                        sum_n   = rdata;
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (cap) begin
                    m_data_n  = rdata;
                    m_valid_n = 1'b1;
                    m_last_n  = ((cnt + 8'd1) == len);
                    cnt_n     = cnt + 8'd1;
                    sum_n     = sum + rdata;
`ifdef UART_PARSER_CSUM_EN
                    if ((cnt + 8'd1) == len) state_n = CHECK;
`endif
                end
`ifndef UART_PARSER_CSUM_EN
                if (payload_done && accept) state_n = HUNT;
`endif
            end
            CHECK: begin
`ifdef UART_PARSER_CSUM_EN
                if (cap) begin
                    if (8'(sum + rdata) == 8'd0) begin
                        ok_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_CSUM;
                    end
                    state_n = HUNT;
                end
`else
                state_n = HUNT;
`endif
            end
            default: state_n = HUNT;
        endcase

        if (tmo_expired) begin
            state_n   = HUNT;
            err_n     = 1'b1;
            code_n    = ERR_TIMEOUT;
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
        end
    end

endmodule
